// File: rtl/tdm_demux.sv
// Receive-side demux for the two-channel TDM link: pairs an X beat with the
// following Y beat and presents them as one registered word.
module tdm_demux #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_sel,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_x,
    output logic [WIDTH-1:0] out_y,
    output logic             seq_err,
    output logic [CNT_W-1:0] pair_count,
    output logic [CNT_W-1:0] err_count
);

    typedef enum logic [1:0] {
        EXP_X = 2'd0,
        EXP_Y = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_hold_q, x_hold_d;
    logic [WIDTH-1:0] out_x_q, out_x_d;
    logic [WIDTH-1:0] out_y_q, out_y_d;
    logic             out_valid_q, out_valid_d;
    logic             seq_err_q, seq_err_d;
    logic [CNT_W-1:0] pair_count_q, pair_count_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;
    logic             accept;
    logic             deliver;
    logic             bad_beat;

    assign in_ready = (state_q != FULL) || out_ready;
    assign accept   = in_valid && in_ready;
    assign deliver  = out_valid_q && out_ready;

    always_comb begin
        state_d      = state_q;
        x_hold_d     = x_hold_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_valid_d  = out_valid_q;
        pair_count_d = pair_count_q;
        bad_beat     = 1'b0;
        unique case (state_q)
            EXP_X: begin
                if (accept && !in_sel) begin
                    x_hold_d = in_data;
                    state_d  = EXP_Y;
                end else if (accept) begin
                    bad_beat = 1'b1;
                end
            end
            EXP_Y: begin
                if (accept && in_sel) begin
                    out_x_d     = x_hold_q;
                    out_y_d     = in_data;
                    out_valid_d = 1'b1;
                    state_d     = FULL;
                end else if (accept) begin
                    x_hold_d = in_data;
                    bad_beat = 1'b1;
                end
            end
            FULL: begin
                // in_ready tracks out_ready here, so accept implies deliver
                if (deliver) begin
                    pair_count_d = pair_count_q + CNT_W'(1);
                    out_valid_d  = 1'b0;
                    state_d      = EXP_X;
                    if (accept && !in_sel) begin
                        x_hold_d = in_data;
                        state_d  = EXP_Y;
                    end else if (accept) begin
                        bad_beat = 1'b1;
                    end
                end
            end
            default: state_d = EXP_X;
        endcase
        seq_err_d   = bad_beat;
        err_count_d = err_count_q;
        if (bad_beat && (err_count_q != {CNT_W{1'b1}})) begin
            err_count_d = err_count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= EXP_X;
            x_hold_q     <= '0;
            out_x_q      <= '0;
            out_y_q      <= '0;
            out_valid_q  <= 1'b0;
            seq_err_q    <= 1'b0;
            pair_count_q <= '0;
            err_count_q  <= '0;
        end else begin
            state_q      <= state_d;
            x_hold_q     <= x_hold_d;
            out_x_q      <= out_x_d;
            out_y_q      <= out_y_d;
            out_valid_q  <= out_valid_d;
            seq_err_q    <= seq_err_d;
            pair_count_q <= pair_count_d;
            err_count_q  <= err_count_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign seq_err    = seq_err_q;
    assign pair_count = pair_count_q;
    assign err_count  = err_count_q;

endmodule
